// File: rtl/lstm_seq_ctrl_if.sv
// Handshake and datapath bundle between the sequence controller, the
// input-vector buffer and the lstm_cell datapath.
// master: the sequencer. slave: the buffer/cell side.
interface lstm_seq_ctrl_if #(
    parameter int unsigned INPUT_SIZE  = 6,
    parameter int unsigned HIDDEN_SIZE = 32,
    parameter int unsigned DATA_WIDTH  = 32
);
    logic                         x_valid;
    logic                         x_ready;
    logic signed [DATA_WIDTH-1:0] x_in        [INPUT_SIZE];
    logic                         cell_start;
    logic                         cell_done;
    logic signed [DATA_WIDTH-1:0] cell_x      [INPUT_SIZE];
    logic signed [DATA_WIDTH-1:0] cell_h_prev [HIDDEN_SIZE];
    logic signed [DATA_WIDTH-1:0] cell_c_prev [HIDDEN_SIZE];
    logic signed [DATA_WIDTH-1:0] cell_h      [HIDDEN_SIZE];
    logic signed [DATA_WIDTH-1:0] cell_c      [HIDDEN_SIZE];

    modport master (
        input  x_valid, x_in, cell_done, cell_h, cell_c,
        output x_ready, cell_start, cell_x, cell_h_prev, cell_c_prev
    );

    modport slave (
        output x_valid, x_in, cell_done, cell_h, cell_c,
        input  x_ready, cell_start, cell_x, cell_h_prev, cell_c_prev
    );
endinterface

// File: rtl/lstm_seq_ctrl.sv
// Sequencer that steps an lstm_cell over seq_len input vectors, holding the
// recurrent h/c state and guarding each cell run with a timeout.
module lstm_seq_ctrl #(
    parameter int unsigned INPUT_SIZE  = 6,
    parameter int unsigned HIDDEN_SIZE = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SEQ_W       = 8,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [SEQ_W-1:0]             seq_len,
    lstm_seq_ctrl_if.master              bus,
    output logic signed [DATA_WIDTH-1:0] h_out [HIDDEN_SIZE],
    output logic signed [DATA_WIDTH-1:0] c_out [HIDDEN_SIZE],
    output logic [SEQ_W-1:0]             step_idx,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_X,
        LAUNCH,
        WAIT_CELL,
        FINISH
    } state_t;

    state_t                       state;
    logic [SEQ_W-1:0]             len_reg;
    logic [CNT_W-1:0]             tmo_cnt;
    logic                         x_ready_r;
    logic                         cell_start_r;
    logic signed [DATA_WIDTH-1:0] x_reg [INPUT_SIZE];
    logic signed [DATA_WIDTH-1:0] h_reg [HIDDEN_SIZE];
    logic signed [DATA_WIDTH-1:0] c_reg [HIDDEN_SIZE];

    assign bus.x_ready     = x_ready_r;
    assign bus.cell_start  = cell_start_r;
    assign bus.cell_x      = x_reg;
    assign bus.cell_h_prev = h_reg;
    assign bus.cell_c_prev = c_reg;
    assign h_out           = h_reg;
    assign c_out           = c_reg;

    // Sequencer FSM; every flag is registered alongside the state it decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            len_reg      <= '0;
            tmo_cnt      <= '0;
            step_idx     <= '0;
            x_ready_r    <= 1'b0;
            cell_start_r <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            x_reg        <= '{default: '0};
            h_reg        <= '{default: '0};
            c_reg        <= '{default: '0};
        end else begin
            cell_start_r <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        h_reg    <= '{default: '0};
                        c_reg    <= '{default: '0};
                        step_idx <= '0;
                        busy     <= 1'b1;
                        if (seq_len != '0) begin
                            len_reg   <= seq_len;
                            x_ready_r <= 1'b1;
                            state     <= WAIT_X;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                WAIT_X: begin
                    if (bus.x_valid) begin
                        x_reg        <= bus.x_in;
                        x_ready_r    <= 1'b0;
                        cell_start_r <= 1'b1;
                        state        <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_CELL;
                end
                WAIT_CELL: begin
                    if (bus.cell_done) begin
                        h_reg <= bus.cell_h;
                        c_reg <= bus.cell_c;
                        if (step_idx == len_reg - SEQ_W'(1)) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            step_idx  <= step_idx + SEQ_W'(1);
                            x_ready_r <= 1'b1;
                            state     <= WAIT_X;
                        end
                    end else if (tmo_cnt == CNT_W'(TIMEOUT)) begin
                        done  <= 1'b1;
                        error <= 1'b1;
                        state <= FINISH;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
